wasm_run_ctrl: RTL and testbench
================================

// Module: wasm_run_ctrl
// PURPOSE
//  Run-control sequencer for the WASM core. Streams a program from a host
//  valid/ready port into the instruction BRAM write port while holding the core
//  in reset, then releases the core. It watches finish/error/stack_full, counts
//  run cycles and reports a final status. Sits between host/bench and WASM_TOP.
// PARAMETERS
//  ADDR_W   10    instr BRAM address width (matches `instr_log2_bram_depth)
//  DATA_W   8     instr BRAM word width
//  CNT_W    32    run-cycle counter width
//  TIMEOUT  1000  watchdog limit in RUN cycles (only used with WASM_RUN_WATCHDOG_EN)
// PORTS
//  clk            in   1        clock
//  rst_n          in   1        async active-low reset
//  i_start        in   1        begin load+run (honoured in IDLE and DONE only)
//  i_abort        in   1        abort load/run
//  i_load_valid   in   1        host program word valid
//  o_load_ready   out  1        ctrl accepts word
//  i_load_data    in   DATA_W   program word
//  i_load_last    in   1        final word of program
//  o_bram_we      out  1        instr BRAM write enable
//  o_bram_waddr   out  ADDR_W   instr BRAM write address
//  o_bram_wdata   out  DATA_W   instr BRAM write data
//  o_core_rst_n   out  1        core reset, active-low, registered
//  i_core_finish  in   1        core o_instr_finish
//  i_core_error   in   1        core o_INSTR_ERROR
//  i_core_stkfull in   1        core o_stack_full
//  o_busy         out  1        state is LOAD, START or RUN
//  o_done         out  1        state is DONE
//  o_status       out  3        0 NONE,1 OK,2 INSTR_ERR,3 STACK_FULL,4 TIMEOUT,5 LOAD_OVF,6 ABORT
//  o_prog_len     out  ADDR_W+1 words accepted in last load
//  o_cycle_cnt    out  CNT_W    RUN cycles elapsed
// BEHAVIOUR
//  Reset: state IDLE, o_core_rst_n=0, o_load_ready=0, o_bram_we=0, addr=0,
//   o_status=0, o_prog_len=0, o_cycle_cnt=0, o_busy=0, o_done=0.
//  FSM: IDLE -> LOAD -> START -> RUN -> DONE. DONE + i_start -> LOAD.
//  IDLE/DONE: i_start=1 -> LOAD. Clear addr, prog_len, cycle_cnt and status.
//   Core stays in reset.
//  LOAD: o_load_ready=1. Handshake = valid&ready. BRAM write is combinational
//   in the handshake cycle: we=1, waddr=addr, wdata=i_load_data. addr and
//   prog_len increment after each handshake.
//   - handshake with last=1 -> START.
//   - handshake at addr=2^ADDR_W-1 with last=0 -> word is written;
//     status=LOAD_OVF -> DONE.
//   - no handshake: wait indefinitely.
//  START: exactly 1 cycle, o_core_rst_n still 0. Lets the final write settle.
//   Then RUN. o_core_rst_n reads 1 in the first RUN cycle.
//  RUN: each cycle, sample core flags with priority error > stkfull > finish.
//   - error -> INSTR_ERR; stkfull -> STACK_FULL; finish -> OK.
//   - each of these -> DONE; o_cycle_cnt holds its value.
//   - otherwise o_cycle_cnt += 1, saturating at all-ones.
//   - k-th RUN cycle (k from 1) carrying finish gives o_cycle_cnt = k-1.
//  DONE: o_core_rst_n=0 (core re-held). o_status, o_prog_len and o_cycle_cnt
//   hold until the next i_start.
//  i_abort: in LOAD/START/RUN -> DONE with status=ABORT; no write that cycle;
//   outranks all other events. In IDLE/DONE it is ignored.
//  i_start outside IDLE/DONE is ignored. i_start and i_abort together in DONE:
//   start wins.
//  Async reset mid-LOAD/RUN returns to the reset values immediately. The core
//   is put in reset asynchronously.
// CONFIGURATION
//  WASM_RUN_WATCHDOG_EN defined:
//   - RUN with no core flag and o_cycle_cnt == TIMEOUT-1 -> DONE, status=TIMEOUT.
//   - o_cycle_cnt then stays at TIMEOUT-1.
//  Not defined:
//   - RUN waits forever; status 4 is never produced; TIMEOUT is unused.
// TESTING
//  1. i_start; 5 words 0x41,0x42,0x43,0x44,0x0B with last on the 5th.
//     -> writes to addr 0..4, o_prog_len=5.
//     -> o_core_rst_n=1 two cycles after the last handshake.
//  2. Run from test 1; finish asserted in 10th RUN cycle
//     -> o_status=1, o_cycle_cnt=9, o_done=1, o_core_rst_n=0.
//  3. Error and finish in the same RUN cycle -> o_status=2.
//     stkfull alone -> o_status=3.
//  4. ADDR_W=2; 4 words, none with last -> 4 writes (addr 0..3),
//     o_status=5, o_prog_len=4, core never released.
//  5. i_abort during LOAD after 2 words -> o_status=6, o_prog_len=2, no 3rd write.
//     Then i_start + 1 last word -> normal load/run.
//  6. WASM_RUN_WATCHDOG_EN, TIMEOUT=1000, no finish
//     -> o_status=4, o_cycle_cnt=999.
//     Without the macro, still RUN after 2000 cycles.

Source files
------------

// File: rtl/wasm_run_ctrl.sv
// Run-control sequencer for the WASM core: streams a program into instruction BRAM, releases the core, and reports the result.
// Optional run watchdog is enabled by defining WASM_RUN_WATCHDOG_EN.
module wasm_run_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [DATA_W-1:0] i_load_data,
  input  logic              i_load_last,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_waddr,
  output logic [DATA_W-1:0] o_bram_wdata,
  output logic              o_core_rst_n,
  input  logic              i_core_finish,
  input  logic              i_core_error,
  input  logic              i_core_stkfull,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_status,
  output logic [ADDR_W:0]   o_prog_len,
  output logic [CNT_W-1:0]  o_cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    ST_NONE       = 3'd0,
    ST_OK         = 3'd1,
    ST_INSTR_ERR  = 3'd2,
    ST_STACK_FULL = 3'd3,
    ST_TIMEOUT    = 3'd4,
    ST_LOAD_OVF   = 3'd5,
    ST_ABORT      = 3'd6
  } status_t;

`ifdef WASM_RUN_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state;
  status_t           status;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   prog_len;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              core_rst_n;
  logic              handshake;
  logic              wd_fire;

  // Abort suppresses the handshake so an aborted cycle never writes BRAM.
  assign o_load_ready = (state == S_LOAD);
  assign handshake    = o_load_ready & i_load_valid & ~i_abort;
  assign wd_fire      = WD_EN && (cycle_cnt == WD_LAST);

  assign o_bram_we    = handshake;
  assign o_bram_waddr = addr;
  assign o_bram_wdata = i_load_data;

  assign o_core_rst_n = core_rst_n;
  assign o_busy       = (state == S_LOAD) || (state == S_START) || (state == S_RUN);
  assign o_done       = (state == S_DONE);
  assign o_status     = status;
  assign o_prog_len   = prog_len;
  assign o_cycle_cnt  = cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      status     <= ST_NONE;
      addr       <= '0;
      prog_len   <= '0;
      cycle_cnt  <= '0;
      core_rst_n <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state     <= S_LOAD;
            status    <= ST_NONE;
            addr      <= '0;
            prog_len  <= '0;
            cycle_cnt <= '0;
          end
        end

        S_LOAD: begin
          if (i_abort) begin
            state  <= S_DONE;
            status <= ST_ABORT;
          end else if (handshake) begin
            addr     <= addr + 1'b1;
            prog_len <= prog_len + 1'b1;
            if (i_load_last) begin
              state <= S_START;
            end else if (addr == '1) begin
              state  <= S_DONE;
              status <= ST_LOAD_OVF;
            end
          end
        end

        S_START: begin
          if (i_abort) begin
            state  <= S_DONE;
            status <= ST_ABORT;
          end else begin
            state      <= S_RUN;
            core_rst_n <= 1'b1;
          end
        end

        S_RUN: begin
          if (i_abort) begin
            state      <= S_DONE;
            status     <= ST_ABORT;
            core_rst_n <= 1'b0;
          end else if (i_core_error) begin
            state      <= S_DONE;
            status     <= ST_INSTR_ERR;
            core_rst_n <= 1'b0;
          end else if (i_core_stkfull) begin
            state      <= S_DONE;
            status     <= ST_STACK_FULL;
            core_rst_n <= 1'b0;
          end else if (i_core_finish) begin
            state      <= S_DONE;
            status     <= ST_OK;
            core_rst_n <= 1'b0;
          end else if (wd_fire) begin
            state      <= S_DONE;
            status     <= ST_TIMEOUT;
            core_rst_n <= 1'b0;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + 1'b1;
          end
        end

        default: begin
          state      <= S_IDLE;
          core_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_run_ctrl.sv
// Self-checking bench for wasm_run_ctrl: directed and randomized load/run scenarios against a behavioural outcome model.
module tb_wasm_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 0, abort = 0, lv = 0, last = 0;
  logic [7:0]  ld = '0;
  logic        fin = 0, err = 0, stk = 0;
  logic        lr, we, core_rst_n, busy, done;
  logic [9:0]  waddr;
  logic [7:0]  wdata;
  logic [2:0]  status;
  logic [10:0] plen;
  logic [31:0] cnt;

  logic        s_start = 0, s_lv = 0;
  logic [7:0]  s_ld = '0;
  logic        s_lr, s_we, s_core_rst_n, s_busy, s_done;
  logic [1:0]  s_waddr;
  logic [7:0]  s_wdata;
  logic [2:0]  s_status;
  logic [2:0]  s_plen;
  logic [31:0] s_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  logic [17:0] wq[$];
  logic [9:0]  swq[$];
  logic [7:0]  prog[$];
  bit          s_released = 0;

  always #5 clk = ~clk;

  wasm_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_load_valid(lv), .o_load_ready(lr), .i_load_data(ld), .i_load_last(last),
    .o_bram_we(we), .o_bram_waddr(waddr), .o_bram_wdata(wdata),
    .o_core_rst_n(core_rst_n), .i_core_finish(fin), .i_core_error(err),
    .i_core_stkfull(stk), .o_busy(busy), .o_done(done), .o_status(status),
    .o_prog_len(plen), .o_cycle_cnt(cnt)
  );

  wasm_run_ctrl #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_abort(1'b0),
    .i_load_valid(s_lv), .o_load_ready(s_lr), .i_load_data(s_ld), .i_load_last(1'b0),
    .o_bram_we(s_we), .o_bram_waddr(s_waddr), .o_bram_wdata(s_wdata),
    .o_core_rst_n(s_core_rst_n), .i_core_finish(1'b0), .i_core_error(1'b0),
    .i_core_stkfull(1'b0), .o_busy(s_busy), .o_done(s_done), .o_status(s_status),
    .o_prog_len(s_plen), .o_cycle_cnt(s_cnt)
  );

  always @(negedge clk) begin
    if (we) wq.push_back({waddr, wdata});
    if (s_we) swq.push_back({s_waddr, s_wdata});
    if (s_core_rst_n) s_released = 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outcome of a run from the core flags present in the terminating cycle.
  function automatic logic [2:0] run_status(input logic e, input logic s, input logic f);
    if (e) return 3'd2;
    if (s) return 3'd3;
    if (f) return 3'd1;
    return 3'd0;
  endfunction

  task automatic chk_writes(input string tag);
    chk({tag, "_nwr"}, wq.size(), prog.size());
    for (int i = 0; i < prog.size() && i < wq.size(); i++) begin
      logic [9:0] a;
      a = i[9:0];
      chk({tag, "_wr"}, wq[i], {a, prog[i]});
    end
    wq.delete();
  endtask

  // Start, load the words in prog (with random idle gaps), run k cycles, flags in cycle k.
  task automatic scenario(input string tag, input int k, input logic e, input logic s,
                          input logic f, input int gap);
    int n;
    n = prog.size();
    wq.delete();
    start = 1; cyc(); start = 0;
    chk({tag, "_busy_load"}, busy, 1);
    chk({tag, "_ready"}, lr, 1);
    chk({tag, "_clr_status"}, status, 0);
    chk({tag, "_clr_cnt"}, cnt, 0);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap > 0) ? $urandom_range(gap, 0) : 0;
      repeat (g) cyc();
      lv = 1; ld = prog[i]; last = (i == n - 1);
      cyc();
      lv = 0; last = 0; ld = '0;
    end
    chk({tag, "_start_rst"}, core_rst_n, 0);
    chk({tag, "_start_ready"}, lr, 0);
    chk({tag, "_plen"}, plen, n);
    cyc();
    chk({tag, "_released"}, core_rst_n, 1);
    for (int j = 1; j <= k; j++) begin
      if (j < k) begin
        start = 1'($urandom_range(1, 0));
        lv    = 1'($urandom_range(1, 0));
      end
      if (j == k) begin
        err = e; stk = s; fin = f;
      end
      cyc();
      start = 0; lv = 0; err = 0; stk = 0; fin = 0;
      if (j == k - 1) chk({tag, "_midcnt"}, cnt, k - 1);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_status"}, status, run_status(e, s, f));
    chk({tag, "_cnt"}, cnt, k - 1);
    chk({tag, "_held"}, core_rst_n, 0);
    chk({tag, "_plen_hold"}, plen, n);
    chk_writes(tag);
  endtask

  initial begin
    repeat (2) cyc();
    chk("rst_core", core_rst_n, 0);
    chk("rst_ready", lr, 0);
    chk("rst_we", we, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_status", status, 0);
    chk("rst_plen", plen, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    cyc();

    abort = 1; cyc(); abort = 0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_status", status, 0);

    prog = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0B};
    scenario("t1", 10, 0, 0, 1, 0);

    prog.delete();
    repeat (3) prog.push_back(8'($urandom));
    scenario("err_fin", 4, 1, 0, 1, 1);
    prog.delete();
    repeat (3) prog.push_back(8'($urandom));
    scenario("stkfull", 7, 0, 1, 0, 1);

    // Abort during load after two accepted words.
    wq.delete();
    prog.delete();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 2; i++) begin
      prog.push_back(8'($urandom));
      lv = 1; ld = prog[i]; last = 0;
      cyc();
    end
    abort = 1; lv = 1; ld = 8'hEE;
    @(negedge clk);
    chk("abort_no_we", we, 0);
    cyc();
    abort = 0; lv = 0;
    chk("abort_done", done, 1);
    chk("abort_status", status, 6);
    chk("abort_plen", plen, 2);
    chk_writes("abort");
    prog = '{8'h5A};
    scenario("after_abort", 1, 0, 0, 1, 0);

    // Start and abort together in DONE: start wins; then abort right in LOAD.
    start = 1; abort = 1; cyc(); start = 0; abort = 0;
    chk("st_ab_busy", busy, 1);
    chk("st_ab_status", status, 0);
    abort = 1; cyc(); abort = 0;
    chk("load_abort_status", status, 6);
    chk("load_abort_plen", plen, 0);

    // Abort in START keeps the core in reset.
    start = 1; cyc(); start = 0;
    lv = 1; last = 1; ld = 8'h01; cyc(); lv = 0; last = 0;
    abort = 1; cyc(); abort = 0;
    chk("start_abort_status", status, 6);
    chk("start_abort_core", core_rst_n, 0);
    cyc();
    chk("start_abort_core2", core_rst_n, 0);
    wq.delete();

    // Asynchronous reset in the middle of a run.
    start = 1; cyc(); start = 0;
    lv = 1; last = 1; cyc(); lv = 0; last = 0;
    repeat (4) cyc();
    chk("pre_arst_core", core_rst_n, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_core", core_rst_n, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cnt", cnt, 0);
    chk("arst_plen", plen, 0);
    cyc();
    rst_n = 1;
    cyc();
    wq.delete();

    for (int r = 0; r < 20; r++) begin
      logic [2:0] fl;
      prog.delete();
      repeat ($urandom_range(24, 1)) prog.push_back(8'($urandom));
      fl = 3'($urandom_range(7, 1));
      scenario("rand", $urandom_range(40, 1), fl[2], fl[1], fl[0], 3);
    end

    // Load overflow on a 4-word BRAM.
    swq.delete();
    s_start = 1; cyc(); s_start = 0;
    for (int i = 0; i < 4; i++) begin
      s_lv = 1; s_ld = 8'(8'h30 + i);
      cyc();
      if (i == 2) chk("ovf_busy_mid", s_busy, 1);
    end
    s_lv = 0;
    chk("ovf_done", s_done, 1);
    chk("ovf_status", s_status, 5);
    chk("ovf_plen", s_plen, 4);
    chk("ovf_core", s_core_rst_n, 0);
    chk("ovf_nwr", swq.size(), 4);
    for (int i = 0; i < 4 && i < swq.size(); i++) begin
      logic [1:0] a;
      a = i[1:0];
      chk("ovf_wr", swq[i], {a, 8'(8'h30 + i)});
    end
    repeat (3) cyc();
    chk("ovf_never_released", s_released, 0);

    // Run with no core flag.
    start = 1; cyc(); start = 0;
    lv = 1; last = 1; cyc(); lv = 0; last = 0;
    cyc();
`ifdef WASM_RUN_WATCHDOG_EN
    repeat (999) cyc();
    chk("wd_pre_busy", busy, 1);
    chk("wd_pre_cnt", cnt, 999);
    cyc();
    chk("wd_done", done, 1);
    chk("wd_status", status, 4);
    chk("wd_cnt", cnt, 999);
    chk("wd_core", core_rst_n, 0);
`else
    repeat (2000) cyc();
    chk("nowd_busy", busy, 1);
    chk("nowd_status", status, 0);
    chk("nowd_cnt", cnt, 2000);
    chk("nowd_core", core_rst_n, 1);
    abort = 1; cyc(); abort = 0;
    chk("run_abort_status", status, 6);
    chk("run_abort_cnt", cnt, 2000);
    chk("run_abort_core", core_rst_n, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
